// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, data-memory and result signals of the load/store unit.
// Ports: requester side drives req_valid/req_store/funct3/addr/wdata, memory drives mem_rd;
//        the LSU drives mem_we/mem_be/mem_a/mem_wd, stall, rdata_valid/rdata and fault.
interface load_store_unit_if;
  // Memory-stage request
  logic        req_valid;
  logic        req_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  // Data-memory port
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  // Pipeline control and load result
  logic        stall;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        fault;

  // Requester plus data memory (pipeline / testbench side)
  modport master (
    output req_valid, req_store, funct3, addr, wdata, mem_rd,
    input  mem_we, mem_be, mem_a, mem_wd, stall, rdata_valid, rdata, fault
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_store, funct3, addr, wdata, mem_rd,
    output mem_we, mem_be, mem_a, mem_wd, stall, rdata_valid, rdata, fault
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V memory-stage load/store unit with byte/half/word access and fault detection.
// Ports: clk, rst_n (async active-low), bus (slave modport of load_store_unit_if).
// Stores complete in the request cycle; loads stall one cycle and return rdata in LOAD_WAIT.
module load_store_unit #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  load_store_unit_if.slave         bus
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        illegal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] st_data;

  logic        mem_we_c;
  logic [3:0]  mem_be_c;
  logic        stall_c;
  logic        rdata_valid_c;
  logic [31:0] rdata_c;
  logic        fault_c;

  // ---------------------------------------------------------------------------
  // Request legality
  // ---------------------------------------------------------------------------
  always_comb begin
    illegal = 1'b0;
    case (bus.funct3)
      F3_B, F3_BU: illegal = 1'b0;
      F3_H, F3_HU: illegal = bus.addr[0];
      F3_W:        illegal = (bus.addr[1:0] != 2'b00);
      default:     illegal = 1'b1;
    endcase
    // Unsigned variants only exist for loads
    if (bus.req_store && bus.funct3[2]) begin
      illegal = 1'b1;
    end
    if ({2'b00, bus.addr[31:2]} >= DEPTH_W) begin
      illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Store data lane replication (memory picks lanes via mem_be)
  // ---------------------------------------------------------------------------
  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   st_data = {4{bus.wdata[7:0]}};
      2'b01:   st_data = {2{bus.wdata[15:0]}};
      default: st_data = bus.wdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data extraction from the latched width code and byte offset
  // ---------------------------------------------------------------------------
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.mem_rd[7:0];
      2'd1:    ld_byte = bus.mem_rd[15:8];
      2'd2:    ld_byte = bus.mem_rd[23:16];
      default: ld_byte = bus.mem_rd[31:24];
    endcase
    ld_half = off_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    case (f3_q)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      F3_W:    ld_data = bus.mem_rd;
      default: ld_data = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && !illegal && !bus.req_store) begin
          state_d = LOAD_WAIT;
          f3_d    = bus.funct3;
          off_d   = bus.addr[1:0];
        end
      end
      LOAD_WAIT: begin
        // Memory word arrives this cycle; the load is done regardless of inputs
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we_c      = 1'b0;
    mem_be_c      = 4'b0000;
    stall_c       = 1'b0;
    rdata_valid_c = 1'b0;
    rdata_c       = 32'd0;
    fault_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (illegal) begin
            fault_c = 1'b1;
          end else if (bus.req_store) begin
            mem_we_c = 1'b1;
            case (bus.funct3[1:0])
              2'b00:   mem_be_c = 4'b0001 << bus.addr[1:0];
              2'b01:   mem_be_c = 4'b0011 << bus.addr[1:0];
              default: mem_be_c = 4'b1111;
            endcase
          end else begin
            stall_c = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        rdata_valid_c = 1'b1;
        rdata_c       = ld_data;
      end
      default: ;
    endcase
    // Input-driven outputs in IDLE would otherwise follow the request while
    // reset is held, so reset masks them directly rather than via state.
    if (!rst_n) begin
      mem_we_c      = 1'b0;
      mem_be_c      = 4'b0000;
      stall_c       = 1'b0;
      rdata_valid_c = 1'b0;
      rdata_c       = 32'd0;
      fault_c       = 1'b0;
    end
  end

  assign bus.mem_a       = {bus.addr[31:2], 2'b00};
  assign bus.mem_wd      = st_data;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_be      = mem_be_c;
  assign bus.stall       = stall_c;
  assign bus.rdata_valid = rdata_valid_c;
  assign bus.rdata       = rdata_c;
  assign bus.fault       = fault_c;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit against a behavioural model.
// Ports: none; drives the master modport of load_store_unit_if and a clk/rst_n pair.
// Directed cases, randomized requests, back-to-back sequencing and mid-load reset.
module tb_load_store_unit;

  localparam int DEPTH = 256;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  load_store_unit_if bus ();

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit model_legal(input int f3, input bit st, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b0;
    if (st && f3 >= 4) return 1'b0;
    if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b0;
    if (f3 == 2 && (a % 4) != 0) return 1'b0;
    if ((a / 4) >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_be(input int f3, input logic [31:0] a);
    logic [3:0] be;
    int size;
    int first;
    be    = 4'b0000;
    size  = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    first = int'(a % 4);
    for (int lane = 0; lane < 4; lane++)
      if (lane >= first && lane < first + size) be[lane] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input int f3, input logic [31:0] w);
    if (f3 == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_rdata(input int f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return rd;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w);
    bus.req_valid = v;
    bus.req_store = st;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = w;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n      = 1'b0;
    bus.mem_rd = 32'hDEAD_BEEF;
    drive(1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678);
    #3;
    tests++;
    if ({bus.mem_we, bus.mem_be, bus.stall, bus.rdata_valid, bus.fault} !== 8'd0 || bus.rdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_store got we=%b be=%b stall=%b rv=%b fault=%b rdata=%h want all 0",
               bus.mem_we, bus.mem_be, bus.stall, bus.rdata_valid, bus.fault, bus.rdata);
    end
    tests++;
    if (bus.mem_a !== 32'h0000_0020) begin
      fails++;
      $display("FAIL reset_mem_a got %h want 00000020", bus.mem_a);
    end
    drive(1'b1, 1'b1, 3'b111, 32'h0000_0021, 32'h0);
    #1;
    tests++;
    if (bus.fault !== 1'b0 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_illegal got fault=%b stall=%b want 0 0", bus.fault, bus.stall);
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if ({bus.mem_we, bus.mem_be, bus.stall, bus.rdata_valid, bus.fault} !== 8'd0 || bus.rdata !== 32'd0) begin
      fails++;
      $display("FAIL idle_novalid got we=%b be=%b stall=%b rv=%b fault=%b want all 0",
               bus.mem_we, bus.mem_be, bus.stall, bus.rdata_valid, bus.fault);
    end
  endtask

  task automatic test_directed;
    // SB to the top byte lane
    drive(1'b1, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5);
    #1;
    tests++;
    if ({bus.mem_we, bus.mem_be, bus.stall, bus.fault} !== 7'b1_1000_0_0 ||
        bus.mem_a !== 32'h0000_0010 || bus.mem_wd !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL sb_lane3 got we=%b be=%b stall=%b a=%h wd=%h want 1 1000 0 00000010 a5a5a5a5",
               bus.mem_we, bus.mem_be, bus.stall, bus.mem_a, bus.mem_wd);
    end
    // LB and LBU with the same memory word
    for (int k = 0; k < 2; k++) begin
      tick();
      drive(1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h0000_0011, 32'h0);
      #1;
      tests++;
      if (bus.stall !== 1'b1 || bus.rdata_valid !== 1'b0) begin
        fails++;
        $display("FAIL lb_accept k=%0d got stall=%b rv=%b want 1 0", k, bus.stall, bus.rdata_valid);
      end
      tick();
      bus.mem_rd = 32'h1234_80FF;
      #1;
      tests++;
      if (bus.rdata_valid !== 1'b1 || bus.stall !== 1'b0 ||
          bus.rdata !== ((k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080)) begin
        fails++;
        $display("FAIL lb_result k=%0d got rv=%b stall=%b rdata=%h", k, bus.rdata_valid, bus.stall, bus.rdata);
      end
    end
    // LH upper half, sign-extended
    tick();
    drive(1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0);
    tick();
    bus.mem_rd = 32'h8001_7FFF;
    #1;
    tests++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'hFFFF_8001) begin
      fails++;
      $display("FAIL lh_result got rv=%b rdata=%h want 1 ffff8001", bus.rdata_valid, bus.rdata);
    end
    // Misaligned SW
    tick();
    drive(1'b1, 1'b1, 3'b010, 32'h0000_0002, 32'hFFFF_FFFF);
    #1;
    tests++;
    if ({bus.fault, bus.mem_we, bus.mem_be, bus.stall} !== 7'b1_0_0000_0) begin
      fails++;
      $display("FAIL sw_misaligned got fault=%b we=%b be=%b stall=%b want 1 0 0000 0",
               bus.fault, bus.mem_we, bus.mem_be, bus.stall);
    end
    // Out-of-range load, then reserved funct3 load
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
    #1;
    tests++;
    if (bus.fault !== 1'b1 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL load_range got fault=%b stall=%b want 1 0", bus.fault, bus.stall);
    end
    tick();
    drive(1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0);
    #1;
    tests++;
    if (bus.fault !== 1'b1 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL load_f3_011 got fault=%b stall=%b want 1 0", bus.fault, bus.stall);
    end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      bit          v;
      bit          st;
      int          f3;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] rd;
      bit          leg;
      bit          e_fault;
      bit          e_we;
      bit          e_stall;
      logic [3:0]  e_be;
      v  = ($urandom_range(0, 5) != 0);
      st = 1'($urandom_range(0, 1));
      f3 = int'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 7));
      w  = $urandom;
      drive(v, st, 3'(f3), a, w);
      leg     = model_legal(f3, st, a);
      e_fault = v && !leg;
      e_we    = v && leg && st;
      e_stall = v && leg && !st;
      e_be    = e_we ? model_be(f3, a) : 4'b0000;
      #1;
      tests++;
      if ({bus.fault, bus.mem_we, bus.mem_be, bus.stall, bus.rdata_valid} !== {e_fault, e_we, e_be, e_stall, 1'b0} ||
          bus.rdata !== 32'd0 || bus.mem_a !== (a & 32'hFFFF_FFFC) ||
          (e_we && bus.mem_wd !== model_wd(f3, w))) begin
        fails++;
        $display("FAIL rand_req n=%0d v=%0d st=%0d f3=%0d a=%h got f=%b we=%b be=%b st=%b rv=%b wd=%h want f=%b we=%b be=%b st=%b",
                 n, v, st, f3, a, bus.fault, bus.mem_we, bus.mem_be, bus.stall, bus.rdata_valid, bus.mem_wd,
                 e_fault, e_we, e_be, e_stall);
      end
      if (e_stall) begin
        tick();
        rd = $urandom;
        bus.mem_rd = rd;
        #1;
        tests++;
        if ({bus.rdata_valid, bus.stall, bus.mem_we, bus.mem_be, bus.fault} !== 8'b1_0_0_0000_0 ||
            bus.rdata !== model_rdata(f3, a, rd)) begin
          fails++;
          $display("FAIL rand_load n=%0d f3=%0d a=%h rd=%h got rv=%b stall=%b rdata=%h want 1 0 %h",
                   n, f3, a, rd, bus.rdata_valid, bus.stall, bus.rdata, model_rdata(f3, a, rd));
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back;
    // LW held through its wait cycle, then SW
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0);
    #1;
    tests++;
    if (bus.stall !== 1'b1 || bus.mem_we !== 1'b0) begin
      fails++;
      $display("FAIL b2b_lw_c0 got stall=%b we=%b want 1 0", bus.stall, bus.mem_we);
    end
    tick();
    bus.mem_rd = 32'hCAFE_F00D;
    #1;
    tests++;
    if ({bus.rdata_valid, bus.stall, bus.mem_we} !== 3'b100 || bus.rdata !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL b2b_lw_c1 got rv=%b stall=%b we=%b rdata=%h want 1 0 0 cafef00d",
               bus.rdata_valid, bus.stall, bus.mem_we, bus.rdata);
    end
    tick();
    drive(1'b1, 1'b1, 3'b010, 32'h0000_000C, 32'h0BAD_CAFE);
    #1;
    tests++;
    if ({bus.mem_we, bus.mem_be, bus.stall, bus.rdata_valid} !== 7'b1_1111_0_0 || bus.mem_wd !== 32'h0BAD_CAFE) begin
      fails++;
      $display("FAIL b2b_sw_c2 got we=%b be=%b stall=%b rv=%b wd=%h want 1 1111 0 0 0badcafe",
               bus.mem_we, bus.mem_be, bus.stall, bus.rdata_valid, bus.mem_wd);
    end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    tests++;
    if (bus.mem_we !== 1'b0) begin
      fails++;
      $display("FAIL b2b_sw_c3 got we=%b want 0", bus.mem_we);
    end
    // Two loads: second accepted two cycles after the first
    tick();
    drive(1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'h0);
    tick();
    bus.mem_rd = 32'h0000_007F;
    tick();
    drive(1'b1, 1'b0, 3'b101, 32'h0000_0016, 32'h0);
    #1;
    tests++;
    if (bus.stall !== 1'b1 || bus.rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ld2_accept got stall=%b rv=%b want 1 0", bus.stall, bus.rdata_valid);
    end
    tick();
    bus.mem_rd = 32'hF00F_1234;
    #1;
    tests++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h0000_F00F) begin
      fails++;
      $display("FAIL b2b_ld2_result got rv=%b rdata=%h want 1 0000f00f", bus.rdata_valid, bus.rdata);
    end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_load;
    drive(1'b1, 1'b0, 3'b000, 32'h0000_0023, 32'h0);
    tick();
    bus.mem_rd = 32'h8000_0000;
    #1;
    tests++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'hFFFF_FF80) begin
      fails++;
      $display("FAIL midrst_pre got rv=%b rdata=%h want 1 ffffff80", bus.rdata_valid, bus.rdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.rdata_valid !== 1'b0 || bus.rdata !== 32'd0 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL midrst_drop got rv=%b rdata=%h stall=%b want 0 0 0", bus.rdata_valid, bus.rdata, bus.stall);
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.rdata_valid !== 1'b0 || bus.rdata !== 32'd0 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL midrst_after got rv=%b rdata=%h stall=%b want 0 0 0", bus.rdata_valid, bus.rdata, bus.stall);
    end
    drive(1'b1, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF);
    #1;
    tests++;
    if ({bus.mem_we, bus.mem_be} !== 5'b1_1100 || bus.mem_wd !== 32'hBEEF_BEEF || bus.rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_idle_sh got we=%b be=%b wd=%h rv=%b want 1 1100 beefbeef 0",
               bus.mem_we, bus.mem_be, bus.mem_wd, bus.rdata_valid);
    end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, number of 32-bit words in the data memory; word indices >= DEPTH_WORDS are out of range.
REQ-002 SHALL use one clock and an asynchronous, active-low reset; all state is clocked on clk.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  memory-stage instruction performs a load or store this cycle.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data (rs2 value).
REQ-010 mem_we  output  1  write enable to data memory.
REQ-011 mem_be  output  4  byte enables to data memory.
REQ-012 mem_a  output  32  word-aligned address to data memory.
REQ-013 mem_wd  output  32  lane-replicated write data to data memory.
REQ-014 mem_rd  input  32  data-memory read word, valid one cycle after address is presented.
REQ-015 stall  output  1  hold the memory stage and all earlier stages.
REQ-016 rdata_valid  output  1  rdata holds a completed load result.
REQ-017 rdata  output  32  extended load result.
REQ-018 fault  output  1  misaligned, out-of-range or illegal-funct3 request; no access performed.

Function
REQ-019 SHALL implement FSM states IDLE and LOAD_WAIT.
REQ-020 mem_a SHALL equal {addr[31:2], 2'b00} at all times.
REQ-021 Legality: SHALL be illegal for funct3 in {011,110,111}, funct3 in {1xx} with req_store=1, H/HU with addr[0]=1, W with addr[1:0]!=00, or addr[31:2] >= DEPTH_WORDS.
REQ-022 In IDLE with req_valid=1 and illegal request: fault=1 combinationally, mem_we=0, mem_be=0000, stall=0, state stays IDLE.
REQ-023 In IDLE, legal store: mem_we=1 same cycle; SB mem_be=0001<<addr[1:0], mem_wd={4{wdata[7:0]}}; SH mem_be=0011<<addr[1:0], mem_wd={2{wdata[15:0]}}; SW mem_be=1111, mem_wd=wdata; stall=0; stays IDLE.
REQ-024 In IDLE, legal load: mem_we=0, mem_be=0000, stall=1; on clock edge latch funct3 and addr[1:0], go to LOAD_WAIT.
REQ-025 In LOAD_WAIT: stall=0, rdata_valid=1, mem_we=0, mem_be=0000; request inputs ignored; next edge returns to IDLE unconditionally.
REQ-026 rdata in LOAD_WAIT from mem_rd via latched offset: B selects byte offset and sign-extends bit 7, BU zero-extends; H selects half addr[1] and sign-extends bit 15, HU zero-extends; W passes mem_rd.
REQ-027 Outside LOAD_WAIT rdata SHALL be 0 and rdata_valid 0.
REQ-028 req_valid=0 in IDLE: mem_we=0, mem_be=0000, stall=0, fault=0.
REQ-029 Load latency: result available exactly one cycle after acceptance; back-to-back loads accepted every second cycle; a store following a load is accepted in the IDLE cycle after LOAD_WAIT.
REQ-030 Requester SHALL hold all request inputs stable while stall=1 and during LOAD_WAIT.

Reset
REQ-031 rst_n=0 SHALL force immediately, independent of clk: state IDLE, latched funct3 000, latched offset 00, stall 0, rdata_valid 0, rdata 0, fault 0, mem_we 0, mem_be 0000.
REQ-032 Reset asserted in LOAD_WAIT SHALL abandon the load with no rdata_valid pulse; first cycle after release is IDLE.

Verification
REQ-033 SB addr=0x0000_0013, wdata=0x0000_00A5 -> same cycle mem_we=1, mem_be=1000, mem_a=0x0000_0010, mem_wd=0xA5A5_A5A5, stall=0.
REQ-034 LB addr=0x0000_0011, mem_rd next cycle=0x1234_80FF -> cycle 0 stall=1; cycle 1 rdata_valid=1, rdata=0xFFFF_FF80; LBU same case -> rdata=0x0000_0080.
REQ-035 LH addr=0x0000_0006, mem_rd=0x8001_7FFF -> rdata=0xFFFF_8001; SW addr=0x0000_0002 -> fault=1, mem_we=0, stall=0.
REQ-036 Address 0x0000_0400 (word 256, DEPTH_WORDS=256) load -> fault=1, no stall; funct3=011 load -> fault=1.
REQ-037 LW then SW held back-to-back -> LW stall 1 cycle, rdata_valid in cycle 1, SW mem_we=1 in cycle 2 only.
REQ-038 Assert rst_n=0 mid-cycle during LOAD_WAIT -> rdata_valid and rdata drop to 0 before next clk edge; after release state IDLE, no result emitted.
